// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined adder/subtractor with a valid/ready handshake on both sides.
//
// The WIDTH-bit carry chain is cut into STAGES segments of SEG = WIDTH/STAGES bits.
// Stage k resolves bits [k*SEG +: SEG] using the carry registered by stage k-1.
// Operands and the partially built sum travel alongside in per-stage registers.
// Latency is STAGES cycles and throughput is one beat per cycle. All stages advance
// together under a single global enable.
//
// Parameters:
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  pipeline depth / number of carry segments (1..WIDTH)
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      synchronous active-low reset; clears all valid bits and sum/cout/ovf
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (!out_valid || out_ready)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result beat valid
//   out_ready  consumer accepts result
//   sum        result
//   cout       raw carry out of the MSB (NOT borrow when subtracting)
//   ovf        two's-complement signed overflow
//
// Build option:
//   ADDSUB_SAT_EN  when defined, sum saturates to the signed max/min on overflow
//                  in the final stage (ovf and cout still report raw values).
module pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic                en;

    logic [STAGES-1:0]   valid_q, valid_d;
    logic [STAGES-1:0]   cy_q, cy_d;
    logic [WIDTH-1:0]    opa_q [STAGES];
    logic [WIDTH-1:0]    opa_d [STAGES];
    logic [WIDTH-1:0]    opb_q [STAGES];
    logic [WIDTH-1:0]    opb_d [STAGES];
    logic [WIDTH-1:0]    sum_q [STAGES];
    logic [WIDTH-1:0]    sum_d [STAGES];
    logic                ovf_q, ovf_d;

    // Inputs seen by each stage: stage 0 takes the port values, stage k the
    // registers of stage k-1.
    logic [STAGES-1:0]   src_valid;
    logic [STAGES-1:0]   src_cy;
    logic [WIDTH-1:0]    src_a   [STAGES];
    logic [WIDTH-1:0]    src_b   [STAGES];
    logic [WIDTH-1:0]    src_sum [STAGES];
    logic [SEG:0]        seg_res [STAGES];
    logic [WIDTH-1:0]    nxt_sum [STAGES];

    logic                ovf_w;
    logic [WIDTH-1:0]    fin_sum;

`ifdef ADDSUB_SAT_EN
    logic [WIDTH-1:0]    sat_max;
    logic [WIDTH-1:0]    sat_min;
    assign sat_max = {WIDTH{1'b1}} >> 1;
    assign sat_min = ~sat_max;
`endif

    always_comb begin
        en = !valid_q[LAST] || out_ready;

        // Subtraction is a + ~b + !cin, so b is inverted once at entry and the
        // initial carry becomes cin ^ sub.
        src_valid[0] = in_valid;
        src_a[0]     = a;
        src_b[0]     = b ^ {WIDTH{sub}};
        src_sum[0]   = '0;
        src_cy[0]    = cin ^ sub;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = opa_q[k-1];
            src_b[k]     = opb_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_cy[k]    = cy_q[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_res[k] = {1'b0, src_a[k][k*SEG +: SEG]}
                       + {1'b0, src_b[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, src_cy[k]};
            nxt_sum[k] = src_sum[k];
            nxt_sum[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
        end

        // The last segment holds the MSB, so overflow is only known here.
        ovf_w = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1])
             && (nxt_sum[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);

        fin_sum = nxt_sum[LAST];
`ifdef ADDSUB_SAT_EN
        if (ovf_w) begin
            fin_sum = src_a[LAST][WIDTH-1] ? sat_min : sat_max;
        end
`endif

        valid_d = valid_q;
        cy_d    = cy_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;

        if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_d[k] = src_valid[k];
                cy_d[k]    = seg_res[k][SEG];
                opa_d[k]   = src_a[k];
                opb_d[k]   = src_b[k];
                sum_d[k]   = (k == LAST) ? fin_sum : nxt_sum[k];
            end
            ovf_d = ovf_w;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= '0;
            cy_q    <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cy_q    <= cy_d;
            ovf_q   <= ovf_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = cy_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined adder/subtractor and the successor to the fixed 8-bit ripple adders.
- The carry chain is split into STAGES segments. One segment is resolved per clock, with one pipeline register between segments.
- Uses a valid/ready handshake on input and output with full backpressure.
- Sits between the operand register file and the result bus in datapath tiles that need WIDTH beyond what one cycle can close.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, pipeline depth = number of carry segments (1..WIDTH); SEG = WIDTH/STAGES bits per segment

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, synchronous, active-low
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: add, 1: subtract
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  raw carry out of MSB
ovf  output  1  two's-complement signed overflow

Behaviour:
- Arithmetic:
  - Add: {cout,sum} = a + b + cin.
  - Sub: {cout,sum} = a + ~b + !cin, i.e. a - b - cin, with cout = NOT borrow.
  - All widths are WIDTH+1 internally, no truncation before cout.
- ovf = (opA[MSB] == opB'[MSB]) && (sum[MSB] != opA[MSB]), where opB' is the inverted b when sub=1.
- Pipeline structure:
  - Stage k (0..STAGES-1) computes segment k bits [k*SEG +: SEG] using the carry registered from stage k-1.
  - Stage 0 uses cin XOR sub-adjusted carry.
  - Unprocessed upper operand segments and completed lower sum segments travel in skew registers alongside a per-stage valid bit.
- Latency: exactly STAGES cycles from accepted input beat to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a global pipeline enable; all stages advance together or hold together.
  - When stalled, every stage register, including sum/cout/ovf, holds its value. out_valid stays high until accepted.
- Bubbles: in_valid=0 while enabled injects an invalid slot. Valid bits shift; data in invalid slots is don't-care but must not raise out_valid.
- Outputs sum/cout/ovf are registered and are stable and meaningful only while out_valid=1.
- Reset (RST_N=0 at a rising edge):
  - All valid bits are cleared.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready reads 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Simultaneous output accept and input accept in the same cycle is legal and loses no beat.

Optional Feature:
ADDSUB_SAT_EN
- Defined: signed saturation in the final stage.
  - When ovf=1, sum is clamped to 0x7F..F if opA[MSB]=0, else 0x80..0.
  - ovf still reports the overflow; cout is unchanged (raw).
  - No added latency.
- Undefined: sum wraps modulo 2^WIDTH. No clamp logic is present.

Test Plan:
1. WIDTH=8, STAGES=2: a=200, b=100, cin=0, sub=0 -> after 2 cycles sum=44, cout=1, ovf=0, out_valid=1 for one cycle with out_ready=1.
2. WIDTH=8, STAGES=2: a=100, b=100, add -> sum=200 (0xC8), cout=0, ovf=1. With ADDSUB_SAT_EN defined: sum=127, ovf=1.
3. WIDTH=8: a=5, b=7, sub=1, cin=0 -> sum=254 (0xFE), cout=0, ovf=0. Then a=7, b=5, sub=1, cin=1 -> sum=1, cout=1.
4. WIDTH=32, STAGES=4: a=0xFFFF_FFFF, b=0, cin=1 -> carry ripples through all segments; sum=0, cout=1 at latency 4.
5. Backpressure: stream 6 back-to-back beats with out_ready=0.
   - in_ready drops after the pipe fills (STAGES beats accepted).
   - Outputs hold stable.
   - Then raise out_ready: all 6 results emerge in order, none duplicated or dropped.
6. Assert RST_N=0 for one cycle while 3 beats are in flight -> next cycle out_valid=0, sum=0, cout=0, ovf=0. No stale result appears afterwards.
